// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register for the 16-bit core.
// Latches the decoded instruction, detects hazards, stalls decode and
// injects NOP bubbles, and resolves ALU operands by forwarding.
// Optional feature macro: ID_EX_FWD_EN (EX/MEM and MEM/WB forwarding).
// Without it the stage interlocks until the producer reaches writeback.
module id_ex_stage #(
  parameter int unsigned OPERAND_WIDTH = 16,
  parameter int unsigned REG_ADDR_W    = 3,
  parameter int unsigned STALL_CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [4:0]               id_opcode,
  input  logic [1:0]               id_funct,
  input  logic [REG_ADDR_W-1:0]    id_rs,
  input  logic [REG_ADDR_W-1:0]    id_rt,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic                     id_rs_used,
  input  logic                     id_use_imm,
  input  logic [OPERAND_WIDTH-1:0] id_rs_data,
  input  logic [OPERAND_WIDTH-1:0] id_rt_data,
  input  logic [OPERAND_WIDTH-1:0] id_imm,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     flush,
  input  logic                     exmem_reg_write,
  input  logic [REG_ADDR_W-1:0]    exmem_rd,
  input  logic [OPERAND_WIDTH-1:0] exmem_result,
  input  logic                     memwb_reg_write,
  input  logic [REG_ADDR_W-1:0]    memwb_rd,
  input  logic [OPERAND_WIDTH-1:0] memwb_result,
  output logic                     id_stall,
  output logic                     ex_valid,
  output logic [4:0]               ex_opcode,
  output logic [1:0]               ex_funct,
  output logic [OPERAND_WIDTH-1:0] ex_ain,
  output logic [OPERAND_WIDTH-1:0] ex_bin,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic [STALL_CNT_W-1:0]   stall_count
);

  logic [REG_ADDR_W-1:0]    rs_q, rt_q;
  logic [OPERAND_WIDTH-1:0] rs_data_q, rt_data_q, imm_q;
  logic                     use_imm_q, rs_used_q;
  logic                     hazard;
  logic                     rs_rd, rt_rd;

  // Which sources the decode-slot instruction actually reads.
  assign rs_rd = id_rs_used;
  assign rt_rd = !id_use_imm;

  // Hazard detection; a flush discards the instruction so it never stalls.
  always_comb begin
    hazard = 1'b0;
`ifdef ID_EX_FWD_EN
    hazard = id_valid && ex_valid && ex_mem_read &&
             ((rs_rd && (ex_rd == id_rs)) || (rt_rd && (ex_rd == id_rt)));
`else
    if (id_valid) begin
      if (ex_valid && ex_reg_write &&
          ((rs_rd && (ex_rd == id_rs)) || (rt_rd && (ex_rd == id_rt))))
        hazard = 1'b1;
      if (exmem_reg_write &&
          ((rs_rd && (exmem_rd == id_rs)) || (rt_rd && (exmem_rd == id_rt))))
        hazard = 1'b1;
    end
`endif
    id_stall = hazard && !flush;
  end

  // ID/EX register: bubble on flush/stall, decode slot when valid, else bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_opcode    <= '0;
      ex_funct     <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      use_imm_q    <= 1'b0;
      rs_used_q    <= 1'b0;
    end else if (flush || id_stall || !id_valid) begin
      ex_valid     <= 1'b0;
      ex_opcode    <= '0;
      ex_funct     <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      use_imm_q    <= 1'b0;
      rs_used_q    <= 1'b0;
    end else begin
      ex_valid     <= 1'b1;
      ex_opcode    <= id_opcode;
      ex_funct     <= id_funct;
      ex_rd        <= id_rd;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      rs_q         <= id_rs;
      rt_q         <= id_rt;
      rs_data_q    <= id_rs_data;
      rt_data_q    <= id_rt_data;
      imm_q        <= id_imm;
      use_imm_q    <= id_use_imm;
      rs_used_q    <= id_rs_used;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (id_stall && (stall_count != '1))
      stall_count <= stall_count + STALL_CNT_W'(1);
  end

`ifdef ID_EX_FWD_EN
  logic [OPERAND_WIDTH-1:0] rs_fwd, rt_fwd;

  // Operand forwarding, EX/MEM over MEM/WB; gated by ex_valid so a bubble
  // with rt index 0 never picks up a producer writing R0.
  always_comb begin
    rs_fwd = rs_data_q;
    rt_fwd = rt_data_q;
    if (ex_valid && rs_used_q) begin
      if (exmem_reg_write && (exmem_rd == rs_q))
        rs_fwd = exmem_result;
      else if (memwb_reg_write && (memwb_rd == rs_q))
        rs_fwd = memwb_result;
    end
    if (ex_valid && !use_imm_q) begin
      if (exmem_reg_write && (exmem_rd == rt_q))
        rt_fwd = exmem_result;
      else if (memwb_reg_write && (memwb_rd == rt_q))
        rt_fwd = memwb_result;
    end
    ex_ain = rs_fwd;
    ex_bin = use_imm_q ? imm_q : rt_fwd;
  end
`else
  logic unused_nofwd;
  assign unused_nofwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result,
                          rs_q, rt_q, rs_used_q};

  // Operands straight from the latched register-file reads or immediate.
  always_comb begin
    ex_ain = rs_data_q;
    ex_bin = use_imm_q ? imm_q : rt_data_q;
  end
`endif

endmodule
